wave_rom_reader: RTL and testbench
==================================

// Module: wave_rom_reader
// PURPOSE
//  Read-side sequencer for the parallel wave-sample ROM set (IC5/IC6/IC7, 8 bits each).
//  Accepts tagged fetch requests from the voice engine over a valid/ready channel.
//  Drives the shared ROM address bus and waits a programmable access time.
//  Captures the three bytes as one 24-bit word and returns it with its tag.
// PARAMETERS
//  ADDR_W       18  ROM address width; matches the IC5/6/7 address bus
//  TAG_W        5   request tag width (voice index); echoed with the response unchanged
//  WAIT_CYCLES  2   clk cycles from address drive to data sample; legal range 1..15
// PORTS
//  clk         in   1        system clock; all logic on the rising edge
//  rst         in   1        synchronous, active-high reset
//  req_valid   in   1        fetch request present
//  req_ready   out  1        request accepted on a cycle with req_valid & req_ready
//  req_addr    in   ADDR_W   ROM byte address to fetch
//  req_tag     in   TAG_W    requester tag
//  rsp_valid   out  1        response word valid
//  rsp_ready   in   1        consumer accepts the response
//  rsp_data    out  24       {rom_data_7, rom_data_6, rom_data_5}
//  rsp_tag     out  TAG_W    tag of the request being answered
//  rom_addr    out  ADDR_W   registered address bus to IC5/IC6/IC7
//  rom_cs      out  1        high while an access is in flight
//  rom_data_5  in   8        IC5 data, combinational from rom_addr
//  rom_data_6  in   8        IC6 data
//  rom_data_7  in   8        IC7 data
// BEHAVIOUR
//  Reset values
//  - state=IDLE; req_ready=0 during rst; rsp_valid=0; rom_cs=0; rom_addr=0; rsp_data=0; rsp_tag=0.
//  - Wait counter cleared. Reset mid-access abandons the fetch; no response is issued.
//  States
//  - IDLE: req_ready=1.
//  - IDLE->ACCESS on accept, at edge T. rom_addr<=req_addr, rom_cs<=1, tag latched, cnt<=WAIT_CYCLES-1.
//  - ACCESS: req_ready=0. cnt decrements each edge.
//  - ACCESS->RESP on the edge where cnt==0 (edge T+WAIT_CYCLES). Data is sampled on that edge.
//    rsp_data<={rom_data_7,rom_data_6,rom_data_5}, rsp_valid<=1, rom_cs<=0.
//  - RESP: rsp_valid, rsp_data and rsp_tag held stable until rsp_valid & rsp_ready.
//  - RESP->IDLE on that handshake edge, with rsp_valid<=0.
//  Latency and throughput
//  - Accept edge to rsp_valid high: exactly WAIT_CYCLES cycles.
//  - With rsp_ready tied high, the next accept is possible 2 edges after rsp_valid rises.
//  - Peak rate is one fetch per WAIT_CYCLES+2 cycles.
//  Other rules
//  - rom_addr holds its last value outside ACCESS; it changes only on an accept.
//  - rsp_ready ignored outside RESP; req_valid ignored outside IDLE; requests are never dropped.
//  - A request that is valid on the handshake edge is accepted one cycle later, in IDLE.
//  - Address width is exact; no wrap or arithmetic is performed on addresses.
// CONFIGURATION
//  ROM_READ_CACHE_EN defined: single-entry last-word cache (cache_addr, cache_data, cache_vld).
//  - Filled on every ACCESS->RESP transition.
//  - Accept with cache_vld & req_addr==cache_addr goes IDLE->RESP directly.
//    That accept uses cache_data, so rsp_valid is high 1 cycle after accept.
//    A cache hit leaves rom_cs low and rom_addr unchanged.
//  - cache_vld is cleared by rst.
//  ROM_READ_CACHE_EN undefined: no cache logic; every request performs an ACCESS.
// TESTING
//  Test 1, reset: assert rst 3 cycles mid-ACCESS -> rsp_valid=0, rom_cs=0, rom_addr=0; no stray response.
//  Test 2, single fetch: WAIT_CYCLES=2, addr=0x00001, tag=3, ROM model bytes 5:0x12 6:0x34 7:0x56.
//    rsp_valid rises 2 cycles after accept, with rsp_data=0x563412 and rsp_tag=3.
//  Test 3, back-pressure: rsp_ready low 10 cycles.
//    rsp_data and rsp_tag stay stable; req_ready stays 0; the next request waits and is accepted after the handshake.
//  Test 4, stream: 8 requests (addr 0..7, tags 0..7) with rsp_ready=1.
//    Responses arrive in order with matching tags, one per WAIT_CYCLES+2 cycles.
//  Test 5, boundary: WAIT_CYCLES=1 and addr=0x3FFFF -> correct data after 1 cycle; rom_addr=0x3FFFF.
//  Test 6, cache (ROM_READ_CACHE_EN): repeat addr 0x00100 -> second rsp 1 cycle after accept, rom_cs never high.
//    After rst, the same addr performs a full ACCESS.

Source files
------------

// File: rtl/wave_rom_reader.sv
// rtl/wave_rom_reader.sv - tagged fetch sequencer for the IC5/IC6/IC7 wave-sample ROM set (optional ROM_READ_CACHE_EN last-word cache)
module wave_rom_reader #(
    parameter int ADDR_W      = 18,
    parameter int TAG_W       = 5,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [23:0]       rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_cs,
    input  logic [7:0]        rom_data_5,
    input  logic [7:0]        rom_data_6,
    input  logic [7:0]        rom_data_7
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // Counter is loaded with WAIT_CYCLES-1 so the sample edge lands WAIT_CYCLES edges after accept
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic [TAG_W-1:0]  tag_q;
    logic              cache_hit;

`ifdef ROM_READ_CACHE_EN
    logic [ADDR_W-1:0] cache_addr;
    logic [23:0]       cache_data;
    logic              cache_vld;

    // A hit needs a valid entry holding exactly the requested address
    assign cache_hit = cache_vld && (req_addr == cache_addr);
`else
    assign cache_hit = 1'b0;
`endif

    // Request/access/response sequencer; all outputs are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
            rom_addr  <= '0;
            rom_cs    <= 1'b0;
            cnt       <= '0;
            tag_q     <= '0;
`ifdef ROM_READ_CACHE_EN
            cache_addr <= '0;
            cache_data <= '0;
            cache_vld  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (cache_hit) begin
`ifdef ROM_READ_CACHE_EN
                            // Hit skips the ROM entirely: bus and chip select untouched
                            rsp_data  <= cache_data;
`endif
                            rsp_tag   <= req_tag;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            rom_addr <= req_addr;
                            rom_cs   <= 1'b1;
                            tag_q    <= req_tag;
                            cnt      <= CNT_INIT;
                            state    <= ACCESS;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        rsp_data  <= {rom_data_7, rom_data_6, rom_data_5};
                        rsp_tag   <= tag_q;
                        rsp_valid <= 1'b1;
                        rom_cs    <= 1'b0;
                        state     <= RESP;
`ifdef ROM_READ_CACHE_EN
                        cache_addr <= rom_addr;
                        cache_data <= {rom_data_7, rom_data_6, rom_data_5};
                        cache_vld  <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Response held until the consumer takes it; a waiting request goes next cycle
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    rom_cs    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_rom_reader.sv
// tb/tb_wave_rom_reader.sv - directed self-checking bench for wave_rom_reader
module tb_wave_rom_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [17:0] req_addr = '0;
    logic [4:0]  req_tag = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [23:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic [17:0] rom_addr;
    logic        rom_cs;
    logic [7:0]  rom_data_5, rom_data_6, rom_data_7;

    logic        req_valid1 = 1'b0;
    logic        req_ready1;
    logic [17:0] req_addr1 = '0;
    logic [4:0]  req_tag1 = '0;
    logic        rsp_valid1;
    logic        rsp_ready1 = 1'b0;
    logic [23:0] rsp_data1;
    logic [4:0]  rsp_tag1;
    logic [17:0] rom_addr1;
    logic        rom_cs1;
    logic [7:0]  rom1_data_5, rom1_data_6, rom1_data_7;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // ROM contents: addr 1 gives bytes 5:0x12 6:0x34 7:0x56
    function automatic logic [7:0] rom5(input logic [17:0] a);
        return a[7:0] ^ 8'h13 ^ {6'b0, a[17:16]};
    endfunction
    function automatic logic [7:0] rom6(input logic [17:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h35;
    endfunction
    function automatic logic [7:0] rom7(input logic [17:0] a);
        return a[7:0] ^ 8'h57;
    endfunction
    function automatic logic [23:0] exp_word(input logic [17:0] a);
        return {rom7(a), rom6(a), rom5(a)};
    endfunction

    assign rom_data_5  = rom5(rom_addr);
    assign rom_data_6  = rom6(rom_addr);
    assign rom_data_7  = rom7(rom_addr);
    assign rom1_data_5 = rom5(rom_addr1);
    assign rom1_data_6 = rom6(rom_addr1);
    assign rom1_data_7 = rom7(rom_addr1);

    wave_rom_reader #(.ADDR_W(18), .TAG_W(5), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .rom_addr(rom_addr), .rom_cs(rom_cs),
        .rom_data_5(rom_data_5), .rom_data_6(rom_data_6), .rom_data_7(rom_data_7)
    );

    wave_rom_reader #(.ADDR_W(18), .TAG_W(5), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1), .req_tag(req_tag1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_tag(rsp_tag1),
        .rom_addr(rom_addr1), .rom_cs(rom_cs1),
        .rom_data_5(rom1_data_5), .rom_data_6(rom1_data_6), .rom_data_7(rom1_data_7)
    );

    // Waits (bounded) for req_ready, issues one request, returns cycles from accept to rsp_valid
    task automatic issue(input logic [17:0] a, input logic [4:0] t, output int lat);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_tag   = t;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        bit stray;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid, rom_cs, rom_addr, rsp_data, rsp_tag} !== '0) begin
            n_err++;
            $display("FAIL reset_values: rdy=%b vld=%b cs=%b addr=%h data=%h tag=%h required all 0",
                     req_ready, rsp_valid, rom_cs, rom_addr, rsp_data, rsp_tag);
        end
        rst = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 18'h00155;
        req_tag   = 5'd7;
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if (rom_cs !== 1'b1 || rom_addr !== 18'h00155) begin
            n_err++;
            $display("FAIL reset_pre_access: cs=%b addr=%h required 1/00155", rom_cs, rom_addr);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || rom_cs !== 1'b0 || rom_addr !== 18'h0 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_access: vld=%b cs=%b addr=%h rdy=%b required 0/0/0/0",
                     rsp_valid, rom_cs, rom_addr, req_ready);
        end
        rst = 1'b0;
        stray = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) stray = 1'b1;
        end
        n_cmp++;
        if (stray !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_stray: stray response=%b required 0", stray);
        end
        lat = 0;
    endtask

    task automatic test_single_fetch();
        int lat;
        bit cs_seen;
        cs_seen = 1'b0;
        fork
            begin
                repeat (3) begin
                    @(negedge clk);
                    if (rom_cs && rom_addr == 18'h00001) cs_seen = 1'b1;
                end
            end
        join_none
        issue(18'h00001, 5'd3, lat);
        n_cmp++;
        if (lat !== 2) begin
            n_err++;
            $display("FAIL single_latency: %0d cycles required 2", lat);
        end
        n_cmp++;
        if (rsp_data !== 24'h563412 || rsp_tag !== 5'd3) begin
            n_err++;
            $display("FAIL single_data: data=%h tag=%0d required 563412/3", rsp_data, rsp_tag);
        end
        n_cmp++;
        if (cs_seen !== 1'b1 || rom_cs !== 1'b0) begin
            n_err++;
            $display("FAIL single_rom_cs: seen=%b now=%b required 1/0", cs_seen, rom_cs);
        end
        handshake();
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_release: vld=%b rdy=%b required 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        bit bad;
        issue(18'h0002A, 5'd9, lat);
        req_valid = 1'b1;
        req_addr  = 18'h0002B;
        req_tag   = 5'd10;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== exp_word(18'h0002A) || rsp_tag !== 5'd9 ||
                req_ready !== 1'b0 || rom_addr !== 18'h0002A) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold: unstable=%b required 0 (data=%h tag=%0d)", bad, rsp_data, rsp_tag);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_handshake: vld=%b rdy=%b required 0/1", rsp_valid, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++;
        if (rom_addr !== 18'h0002B || rom_cs !== 1'b1) begin
            n_err++;
            $display("FAIL bp_next_accept: addr=%h cs=%b required 0002b/1", rom_addr, rom_cs);
        end
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (rsp_tag !== 5'd10 || rsp_data !== exp_word(18'h0002B)) begin
            n_err++;
            $display("FAIL bp_next_rsp: tag=%0d data=%h required 10/%h", rsp_tag, rsp_data, exp_word(18'h0002B));
        end
        handshake();
    endtask

    task automatic test_stream();
        int idx_req = 0;
        int idx_rsp = 0;
        int last_cyc = 0;
        bit pend = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 18'd0;
        req_tag   = 5'd0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (pend) begin
                idx_req++;
                if (idx_req < 8) begin
                    req_addr = 18'(idx_req);
                    req_tag  = 5'(idx_req);
                end else begin
                    req_valid = 1'b0;
                end
            end
            pend = req_valid && req_ready;
            if (rsp_valid) begin
                n_cmp++;
                if (rsp_tag !== 5'(idx_rsp) || rsp_data !== exp_word(18'(idx_rsp))) begin
                    n_err++;
                    $display("FAIL stream_rsp%0d: tag=%0d data=%h required %0d/%h",
                             idx_rsp, rsp_tag, rsp_data, idx_rsp, exp_word(18'(idx_rsp)));
                end
                if (idx_rsp > 0) begin
                    n_cmp++;
                    if (cyc - last_cyc !== 4) begin
                        n_err++;
                        $display("FAIL stream_period%0d: %0d cycles required 4", idx_rsp, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                idx_rsp++;
            end
            if (idx_rsp == 8) break;
            @(negedge clk);
        end
        n_cmp++;
        if (idx_rsp !== 8) begin
            n_err++;
            $display("FAIL stream_count: %0d responses required 8", idx_rsp);
        end
        req_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_boundary();
        int lat;
        int n = 0;
        while (!req_ready1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid1 = 1'b1;
        req_addr1  = 18'h3FFFF;
        req_tag1   = 5'd31;
        @(negedge clk);
        req_valid1 = 1'b0;
        n_cmp++;
        if (rom_addr1 !== 18'h3FFFF || rom_cs1 !== 1'b1) begin
            n_err++;
            $display("FAIL bound_addr: addr=%h cs=%b required 3ffff/1", rom_addr1, rom_cs1);
        end
        lat = 0;
        while (!rsp_valid1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat !== 1 || rsp_data1 !== 24'hA835EF || rsp_tag1 !== 5'd31) begin
            n_err++;
            $display("FAIL bound_rsp: lat=%0d data=%h tag=%0d required 1/a835ef/31", lat, rsp_data1, rsp_tag1);
        end
        rsp_ready1 = 1'b1;
        @(negedge clk);
        rsp_ready1 = 1'b0;
        n_cmp++;
        if (rsp_valid1 !== 1'b0 || rom_addr1 !== 18'h3FFFF) begin
            n_err++;
            $display("FAIL bound_release: vld=%b addr=%h required 0/3ffff", rsp_valid1, rom_addr1);
        end
    endtask

`ifdef ROM_READ_CACHE_EN
    task automatic test_cache();
        int lat;
        bit cs_seen;
        logic [17:0] addr_before;
        issue(18'h00100, 5'd1, lat);
        handshake();
        addr_before = rom_addr;
        cs_seen = 1'b0;
        fork
            begin
                repeat (4) begin
                    @(negedge clk);
                    if (rom_cs) cs_seen = 1'b1;
                end
            end
        join_none
        issue(18'h00100, 5'd2, lat);
        n_cmp++;
        if (lat !== 1 || rsp_data !== exp_word(18'h00100) || rsp_tag !== 5'd2) begin
            n_err++;
            $display("FAIL cache_hit: lat=%0d data=%h tag=%0d required 1/%h/2", lat, rsp_data, rsp_tag, exp_word(18'h00100));
        end
        handshake();
        n_cmp++;
        if (cs_seen !== 1'b0 || rom_addr !== addr_before) begin
            n_err++;
            $display("FAIL cache_no_access: cs_seen=%b addr=%h required 0/%h", cs_seen, rom_addr, addr_before);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(18'h00100, 5'd4, lat);
        n_cmp++;
        if (lat !== 2 || rsp_data !== exp_word(18'h00100)) begin
            n_err++;
            $display("FAIL cache_after_rst: lat=%0d data=%h required 2/%h", lat, rsp_data, exp_word(18'h00100));
        end
        handshake();
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_single_fetch();
        test_back_pressure();
        test_stream();
        test_boundary();
`ifdef ROM_READ_CACHE_EN
        test_cache();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
